// File: rtl/mcu_spi_rx.sv
// SPI mode-0 slave receiving MCU frames: byte 0 selects a target, later bytes
// are forwarded as strobed payload, and a reply byte is shifted back on MISO.
`timescale 1ns/1ps
module mcu_spi_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  REPLY_IDLE  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] target,
    output logic       data_in_strobe,
    output logic       data_in_start,
    output logic [7:0] data_in,
    input  logic [7:0] reply_in,
    output logic       overrun
);

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_hist_r;
    logic                   cs_hist_r;
    logic                   armed_r;
    logic                   reply_pend_r;
    logic [2:0]             bit_cnt_r;
    logic [1:0]             byte_idx_r;
    logic [6:0]             rx_shift_r;
    logic [7:0]             tx_shift_r;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   cs_rise_s;
    logic                   idle_s;
    logic                   last_bit_s;
    logic [7:0]             byte_s;

    // Oversampling synchronisers for the three asynchronous SPI pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_r <= '0;
            cs_sync_r   <= '0;
            mosi_sync_r <= '0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign sclk_s     = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s       = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign rise_s     = sclk_s & ~sclk_hist_r;
    assign fall_s     = ~sclk_s & sclk_hist_r;
    assign cs_rise_s  = cs_s & ~cs_hist_r;
    // After reset the link stays idle until cs_n has been seen high once.
    assign idle_s     = cs_s | ~armed_r;
    assign byte_s     = {rx_shift_r, mosi_s};
    assign last_bit_s = rise_s & ~idle_s & (bit_cnt_r == 3'd7);
    assign spi_miso   = tx_shift_r[7];

    // Frame state machine: bit/byte tracking, byte decode and reply shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_hist_r    <= 1'b0;
            cs_hist_r      <= 1'b0;
            armed_r        <= 1'b0;
            reply_pend_r   <= 1'b0;
            bit_cnt_r      <= 3'd0;
            byte_idx_r     <= 2'd0;
            rx_shift_r     <= 7'd0;
            tx_shift_r     <= 8'h00;
            target         <= 8'h00;
            data_in        <= 8'h00;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            sclk_hist_r    <= sclk_s;
            cs_hist_r      <= cs_s;
            reply_pend_r   <= data_in_strobe;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            if (cs_s) begin
                armed_r <= 1'b1;
            end
            if (idle_s) begin
                bit_cnt_r  <= 3'd0;
                byte_idx_r <= 2'd0;
                tx_shift_r <= REPLY_IDLE;
                // A frame closed mid-byte loses the partial byte.
                if (cs_rise_s && armed_r && (bit_cnt_r != 3'd0)) begin
                    overrun <= 1'b1;
                end
            end else begin
                if (rise_s) begin
                    rx_shift_r <= byte_s[6:0];
                    bit_cnt_r  <= bit_cnt_r + 3'd1;
                end
                if (last_bit_s) begin
                    overrun <= 1'b0;
                    case (byte_idx_r)
                        2'd0: begin
                            target     <= byte_s;
                            byte_idx_r <= 2'd1;
                            tx_shift_r <= REPLY_IDLE;
                        end
                        2'd1: begin
                            data_in        <= byte_s;
                            data_in_strobe <= 1'b1;
                            data_in_start  <= 1'b1;
                            byte_idx_r     <= 2'd2;
                        end
                        default: begin
                            data_in        <= byte_s;
                            data_in_strobe <= 1'b1;
                            data_in_start  <= 1'b0;
                            byte_idx_r     <= 2'd2;
                        end
                    endcase
                end else if (reply_pend_r) begin
                    tx_shift_r <= reply_in;
                end else if (fall_s && (bit_cnt_r != 3'd0)) begin
                    tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_mcu_spi_rx.sv
// Bench for mcu_spi_rx: an MCU model drives frames at 8x oversampling and
// queues expected payload bytes; a monitor pops them on every strobe.
`timescale 1ns/1ps
module tb_mcu_spi_rx;

    localparam logic [7:0] IDLE = 8'h3C;
    localparam int         HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] target;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [7:0] reply_in;
    logic       overrun;

    int         n_checks    = 0;
    int         n_fail      = 0;
    int         strobe_cnt  = 0;
    int         stray_start = 0;
    int         s0;
    logic       prev_strobe = 1'b0;
    logic [8:0] exp_q [$];
    logic [8:0] mon_exp;
    logic [7:0] fbytes [0:31];

    mcu_spi_rx #(.SYNC_STAGES(2), .REPLY_IDLE(IDLE)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_sclk       (spi_sclk),
        .spi_cs_n       (spi_cs_n),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .target         (target),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .reply_in       (reply_in),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued byte.
    always @(negedge clk) begin
        if (data_in_start && !data_in_strobe) stray_start++;
        if (data_in_strobe) begin
            strobe_cnt++;
            check("strobe spacing", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected strobe: data_in %0h start %0b, no byte expected",
                         data_in, data_in_start);
            end else begin
                mon_exp = exp_q.pop_front();
                check("payload {start,data}", {23'd0, data_in_start, data_in}, {23'd0, mon_exp});
            end
        end
        prev_strobe = data_in_strobe;
    end

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            #(HALF-1);
            rx = {rx[6:0], spi_miso};
            #1 spi_sclk = 1'b1;
            #HALF spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbytes, input int partial, input bit chk, input logic [7:0] reply);
        logic [7:0] rx;
        reply_in = reply;
        #($urandom_range(0, 9));
        spi_cs_n = 1'b0;
        for (int b = 0; b < nbytes; b++) begin
            if (chk && b > 0) exp_q.push_back({(b == 1), fbytes[b]});
            xfer(fbytes[b], 8, rx);
            if (chk) check("miso byte", {24'd0, rx}, {24'd0, (b < 2) ? IDLE : reply});
        end
        if (partial > 0) xfer(8'hFF, partial, rx);
        #HALF spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #60;
        if (chk && nbytes > 0) check("target", {24'd0, target}, {24'd0, fbytes[0]});
    endtask

    initial begin
        reset    = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        reply_in = 8'h00;
        #23;
        check("reset outputs", {12'd0, target, data_in, data_in_strobe, data_in_start, overrun, spi_miso}, 32'd0);
        reset = 1'b0;
        #50;

        // Basic frame with a reply on the third byte.
        fbytes[0] = 8'h03; fbytes[1] = 8'h01; fbytes[2] = 8'h9A;
        run_frame(3, 0, 1'b1, 8'hC5);
        check("overrun after clean frame", {31'd0, overrun}, 32'd0);

        // Long frame: byte index saturates, no target re-decode.
        fbytes[0] = 8'h02;
        for (int i = 1; i < 20; i++) fbytes[i] = 8'(i - 1);
        s0 = strobe_cnt;
        run_frame(20, 0, 1'b1, 8'h5A);
        check("long frame strobe count", strobe_cnt - s0, 32'd19);

        // Frame closed after 5 bits of a payload byte.
        fbytes[0] = 8'h05; fbytes[1] = 8'h11;
        run_frame(2, 5, 1'b1, 8'h00);
        check("overrun set", {31'd0, overrun}, 32'd1);
        check("data_in held", {24'd0, data_in}, 32'h11);
        fbytes[0] = 8'h07;
        run_frame(1, 0, 1'b1, 8'h00);
        check("overrun cleared", {31'd0, overrun}, 32'd0);

        // Reset mid-byte while the MCU keeps clocking the frame.
        fbytes[0] = 8'h0A; fbytes[1] = 8'h0B; fbytes[2] = 8'h0C;
        s0 = strobe_cnt;
        fork
            run_frame(3, 0, 1'b0, 8'h77);
            begin
                #150 reset = 1'b1;
                #1;
                check("mid-frame reset outputs",
                      {12'd0, target, data_in, data_in_strobe, data_in_start, overrun, spi_miso}, 32'd0);
                #20 reset = 1'b0;
            end
        join
        check("no strobe after reset", strobe_cnt - s0, 32'd0);
        fbytes[0] = 8'h0D; fbytes[1] = 8'h0E;
        run_frame(2, 0, 1'b1, 8'h00);
        check("overrun after reset frame", {31'd0, overrun}, 32'd0);

        // Random frames with random phase against the clock.
        for (int f = 0; f < 250; f++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) fbytes[b] = 8'($urandom);
            run_frame(n, 0, 1'b1, 8'($urandom));
        end

        #100;
        check("queue drained", exp_q.size(), 32'd0);
        check("start without strobe", stray_start, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
